// File: rtl/cp0_timer_ctrl.sv
// CP0 register file and exception controller for the MEM stage of the 5-stage MIPS core.
// Holds Count/Compare timer, interrupt pending logic, EPC/BadVAddr capture and the redirect target.
module cp0_timer_ctrl #(
  parameter int unsigned HW_INT_NUM     = 6,
  parameter int unsigned TIMER_IRQ_LINE = 5,
  parameter int unsigned COUNT_DIV      = 2,
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [4:0]            raddr,
  output logic [31:0]           data_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  eret_i,
  output logic                  flush,
  output logic [31:0]           exc_target,
  output logic                  int_pending,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]    im_q;
  logic          exl_q, ie_q;
  logic          bd_q, ti_q;
  logic [5:0]    ip_hw_q;
  logic [1:0]    ip_sw_q;
  logic [4:0]    exccode_q;
  logic [PW-1:0] presc_q;

  logic        mtc0;
  logic        wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        count_tick;
  logic [31:0] count_inc;
  logic        ti_next;
  logic [5:0]  ip_hw_next;
  logic        exc_addr_err;
  logic [31:0] status_w, cause_w;

  // mtc0 is squashed by a same-cycle exception; eret lets it through
  always_comb begin
    mtc0         = we & ~exc_valid;
    wr_badvaddr  = mtc0 && (waddr == A_BADVADDR);
    wr_count     = mtc0 && (waddr == A_COUNT);
    wr_compare   = mtc0 && (waddr == A_COMPARE);
    wr_status    = mtc0 && (waddr == A_STATUS);
    wr_cause     = mtc0 && (waddr == A_CAUSE);
    wr_epc       = mtc0 && (waddr == A_EPC);
    count_tick   = (presc_q == PRESC_LAST);
    count_inc    = count_q + 32'd1;
    exc_addr_err = (exccode_i == 5'h04) || (exccode_i == 5'h05);
  end

  always_comb begin
    ti_next = ti_q;
    if (wr_compare)
      ti_next = 1'b0;
    else if (count_tick && !wr_count && (count_inc == compare_q))
      ti_next = 1'b1;
    ip_hw_next = 6'(int_i) | (6'(ti_next) << TIMER_IRQ_LINE);
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      presc_q    <= '0;
    end else begin
      presc_q <= (wr_count || count_tick) ? '0 : presc_q + PW'(1);
      if (wr_count)
        count_q <= wdata;
      else if (count_tick)
        count_q <= count_inc;
      if (wr_compare)
        compare_q <= wdata;
      ti_q    <= ti_next;
      ip_hw_q <= ip_hw_next;

      if (exc_valid) begin
        exl_q     <= 1'b1;
        exccode_q <= exccode_i;
        if (!exl_q) begin
          epc_q <= in_delay_i ? (pc_i - 32'd4) : pc_i;
          bd_q  <= in_delay_i;
        end
        if (exc_addr_err)
          badvaddr_q <= badvaddr_i;
      end else begin
        if (wr_status) begin
          im_q  <= wdata[15:8];
          ie_q  <= wdata[0];
          exl_q <= wdata[1] & ~eret_i;
        end else if (eret_i) begin
          exl_q <= 1'b0;
        end
        if (wr_cause)
          ip_sw_q <= wdata[9:8];
        if (wr_epc)
          epc_q <= wdata;
        if (wr_badvaddr)
          badvaddr_q <= wdata;
      end
    end
  end

  always_comb begin
    status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    cause_w  = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
  end

  always_comb begin
    data_o = '0;
    if (re) begin
      unique case (raddr)
        A_BADVADDR: data_o = badvaddr_q;
        A_COUNT:    data_o = count_q;
        A_COMPARE:  data_o = compare_q;
        A_STATUS:   data_o = status_w;
        A_CAUSE:    data_o = cause_w;
        A_EPC:      data_o = epc_q;
        default:    data_o = '0;
      endcase
    end
  end

  // eret redirect bypasses a same-cycle mtc0 EPC so the return lands on the new value
  always_comb begin
    flush       = 1'b0;
    exc_target  = '0;
    int_pending = 1'b0;
    if (cpu_rst) begin
      exc_target = RESET_VECTOR;
    end else begin
      flush       = exc_valid | eret_i;
      int_pending = ie_q & ~exl_q & (|(cause_w[15:8] & im_q));
      if (exc_valid)
        exc_target = EXC_VECTOR;
      else if (eret_i)
        exc_target = (we && (waddr == A_EPC)) ? wdata : epc_q;
    end
  end

  assign status_o = status_w;
  assign cause_o  = cause_w;
  assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Directed bench for cp0_timer_ctrl: stimulus pushes expected read/flush/target/pending
// into a queue, a negedge monitor pops and compares whenever re is asserted.
module tb_cp0_timer_ctrl;

  localparam logic [31:0] EXC_V = 32'hBFC00380;
  localparam logic [31:0] RST_V = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [4:0]  raddr = '0;
  logic [31:0] data_o;
  logic [5:0]  int_i = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exccode_i = '0;
  logic [31:0] pc_i = '0;
  logic        in_delay_i = 1'b0;
  logic [31:0] badvaddr_i = '0;
  logic        eret_i = 1'b0;
  logic        flush;
  logic [31:0] exc_target;
  logic        int_pending;
  logic [31:0] status_o, cause_o, epc_o;

  cp0_timer_ctrl #(
    .HW_INT_NUM(6), .TIMER_IRQ_LINE(5), .COUNT_DIV(2),
    .EXC_VECTOR(EXC_V), .RESET_VECTOR(RST_V)
  ) dut (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .data_o(data_o), .int_i(int_i), .exc_valid(exc_valid),
    .exccode_i(exccode_i), .pc_i(pc_i), .in_delay_i(in_delay_i), .badvaddr_i(badvaddr_i),
    .eret_i(eret_i), .flush(flush), .exc_target(exc_target), .int_pending(int_pending),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        fl;
    logic [31:0] tgt;
    logic        pend;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (re) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = sb.pop_front();
        chk({it.name, "_data"}, data_o, it.data);
        chk({it.name, "_flush"}, {31'b0, flush}, {31'b0, it.fl});
        chk({it.name, "_target"}, exc_target, it.tgt);
        chk({it.name, "_pend"}, {31'b0, int_pending}, {31'b0, it.pend});
      end
    end else begin
      chk("re_low_data", data_o, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n,
                    input logic ef, input logic [31:0] et, input logic ep);
    item_t it;
    it.name = n; it.data = e; it.fl = ef; it.tgt = et; it.pend = ep;
    sb.push_back(it);
    re = 1'b1;
    raddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic set_exc(input logic [4:0] c, input logic [31:0] pc, input logic dly, input logic [31:0] bva);
    exc_valid = 1'b1; exccode_i = c; pc_i = pc; in_delay_i = dly; badvaddr_i = bva;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, and flush held low under reset even with eret asserted
    tick(); tick();
    eret_i = 1'b1;
    rd(12, 32'h0040_0000, "rst_status", 1'b0, RST_V, 1'b0);
    cpu_rst = 1'b0; eret_i = 1'b0;
    repeat (10) tick();
    rd(9, 32'd5, "count_div2", 1'b0, 0, 1'b0);
    rd(13, 32'd0, "rst_cause", 1'b0, 0, 1'b0);

    // timer interrupt
    wr(11, 32'h12);
    wr(12, 32'h0000_8001);
    wr(9, 32'h10);
    tick(); tick(); tick();
    rd(13, 32'd0, "ti_early", 1'b0, 0, 1'b0);
    rd(13, 32'h4000_8000, "ti_set", 1'b0, 0, 1'b1);
    we = 1'b1; waddr = 11; wdata = 32'h100;
    rd(13, 32'h4000_8000, "ti_prewrite", 1'b0, 0, 1'b1);
    we = 1'b0;
    rd(13, 32'd0, "ti_clr", 1'b0, 0, 1'b0);
    rd(9, 32'h13, "count_run", 1'b0, 0, 1'b0);

    // hardware line 0 -> IP2
    int_i = 6'b000001;
    tick();
    rd(13, 32'h0000_0400, "hw_ip2", 1'b0, 0, 1'b0);
    wr(12, 32'h0000_0401);
    rd(12, 32'h0040_0401, "hw_pend", 1'b0, 0, 1'b1);
    int_i = '0;
    tick();
    wr(13, 32'h0000_0300);
    rd(13, 32'h0000_0300, "sw_ip", 1'b0, 0, 1'b0);
    wr(12, 32'd0);

    // AdEL in delay slot
    set_exc(5'h04, 32'h8000_1008, 1'b1, 32'h3);
    rd(8, 32'd0, "exc1", 1'b1, EXC_V, 1'b0);
    exc_valid = 1'b0;
    rd(14, 32'h8000_1004, "exc1_epc", 1'b0, 0, 1'b0);
    rd(13, 32'h8000_0310, "exc1_cause", 1'b0, 0, 1'b0);
    rd(8, 32'h3, "exc1_bva", 1'b0, 0, 1'b0);
    rd(12, 32'h0040_0002, "exc1_status", 1'b0, 0, 1'b0);

    // nested exception with EXL=1
    set_exc(5'h08, 32'h2000, 1'b0, 32'h55);
    rd(13, 32'h8000_0310, "exc2", 1'b1, EXC_V, 1'b0);
    exc_valid = 1'b0;
    rd(14, 32'h8000_1004, "exc2_epc", 1'b0, 0, 1'b0);
    rd(13, 32'h8000_0320, "exc2_cause", 1'b0, 0, 1'b0);
    rd(8, 32'h3, "exc2_bva", 1'b0, 0, 1'b0);

    // eret with EPC bypass
    eret_i = 1'b1; we = 1'b1; waddr = 14; wdata = 32'h8000_2000;
    rd(12, 32'h0040_0002, "eret1", 1'b1, 32'h8000_2000, 1'b0);
    eret_i = 1'b0; we = 1'b0;
    rd(12, 32'h0040_0000, "eret1_status", 1'b0, 0, 1'b0);
    rd(14, 32'h8000_2000, "eret1_epc", 1'b0, 0, 1'b0);

    // eret with mtc0 Status: EXL forced low
    eret_i = 1'b1; we = 1'b1; waddr = 12; wdata = 32'h0000_FF03;
    rd(14, 32'h8000_2000, "eret2", 1'b1, 32'h8000_2000, 1'b0);
    eret_i = 1'b0; we = 1'b0;
    rd(12, 32'h0040_FF01, "eret2_status", 1'b0, 0, 1'b1);
    wr(12, 32'd0);

    // exception drops a same-cycle mtc0
    set_exc(5'h00, 32'h3000, 1'b0, 32'h77);
    we = 1'b1; waddr = 12; wdata = 32'h1;
    rd(12, 32'h0040_0000, "exc3", 1'b1, EXC_V, 1'b0);
    exc_valid = 1'b0; we = 1'b0;
    rd(12, 32'h0040_0002, "exc3_status", 1'b0, 0, 1'b0);
    rd(14, 32'h3000, "exc3_epc", 1'b0, 0, 1'b0);
    rd(13, 32'h0000_0300, "exc3_cause", 1'b0, 0, 1'b0);
    eret_i = 1'b1;
    rd(12, 32'h0040_0002, "eret3", 1'b1, 32'h3000, 1'b0);
    eret_i = 1'b0;
    rd(12, 32'h0040_0000, "eret3_status", 1'b0, 0, 1'b0);

    // Count wrap, and mtc0 Count beats a pending increment
    wr(9, 32'hFFFF_FFFF);
    tick();
    rd(9, 32'hFFFF_FFFF, "wrap_pre", 1'b0, 0, 1'b0);
    rd(9, 32'd0, "wrap", 1'b0, 0, 1'b0);
    wr(9, 32'h50);
    rd(9, 32'h50, "cnt_load", 1'b0, 0, 1'b0);
    rd(9, 32'h50, "cnt_hold", 1'b0, 0, 1'b0);
    rd(9, 32'h51, "cnt_inc", 1'b0, 0, 1'b0);

    // Compare write beats a same-cycle match
    wr(11, 32'h60);
    wr(9, 32'h5F);
    tick();
    we = 1'b1; waddr = 11; wdata = 32'h60;
    rd(13, 32'h0000_0300, "ti_race_pre", 1'b0, 0, 1'b0);
    we = 1'b0;
    rd(13, 32'h0000_0300, "ti_race", 1'b0, 0, 1'b0);
    rd(9, 32'h60, "ti_race_cnt", 1'b0, 0, 1'b0);

    wr(10, 32'hDEAD_BEEF);
    rd(10, 32'd0, "unmapped", 1'b0, 0, 1'b0);

    // reset mid-operation overrides an exception
    cpu_rst = 1'b1;
    set_exc(5'h04, 32'h4000, 1'b0, 32'h99);
    tick();
    rd(12, 32'h0040_0000, "rst2_status", 1'b0, RST_V, 1'b0);
    rd(13, 32'd0, "rst2_cause", 1'b0, RST_V, 1'b0);
    rd(9, 32'd0, "rst2_count", 1'b0, RST_V, 1'b0);
    cpu_rst = 1'b0; exc_valid = 1'b0;
    rd(8, 32'd0, "rst2_bva", 1'b0, 0, 1'b0);
    tick();
    chk("sb_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
